// File: rtl/legv8_pkg.sv
// Shared LegV8 core types and widths used by the fetch/decode queue.
package legv8_pkg;
  localparam int LEGV8_INSTR_W = 32;
  localparam int LEGV8_ADDR_W  = 64;

  typedef logic [LEGV8_INSTR_W-1:0] instr_t;
  typedef logic [LEGV8_ADDR_W-1:0]  pc_t;
endpackage

// File: rtl/instruction_queue_if.sv
// Fetch/decode handshake bundle for instruction_queue.
// master = fetch + decode side (drives pushes, pops and flush), slave = queue.
interface instruction_queue_if
  import legv8_pkg::*;
#(
  parameter int N  = LEGV8_INSTR_W,
  parameter int AW = LEGV8_ADDR_W,
  parameter int CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_instr;
  logic [AW-1:0] in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_instr;
  logic [AW-1:0] out_pc;
  logic          flush;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/queue_storage.sv
// DEPTH x W register file: one synchronous write port, one asynchronous
// read port, all entries cleared by async reset.
module queue_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  // Entry write; contents persist across pops and flushes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instruction_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode.
// Optional macro INSTRUCTION_QUEUE_PC_TAG_EN builds a PC tag array alongside
// the instruction array; without it in_pc is ignored and out_pc reads 0.
module instruction_queue
  import legv8_pkg::*;
#(
  parameter int N     = LEGV8_INSTR_W,
  parameter int DEPTH = 4,
  parameter int AW    = LEGV8_ADDR_W
) (
  input logic                 clock,
  input logic                 reset,
  instruction_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Ready/valid come only from registered count, so a pop never frees a
  // slot for a push in the same cycle.
  assign q.in_ready  = (count_q < CW'(DEPTH));
  assign q.out_valid = (count_q != '0);
  assign q.count     = count_q;

  assign push = q.in_valid  && q.in_ready  && !q.flush;
  assign pop  = q.out_valid && q.out_ready && !q.flush;

  // Next pointers/count; flush returns everything to zero and wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = PW'(wr_ptr_q + 1'b1);
      if (pop)  rd_ptr_d = PW'(rd_ptr_q + 1'b1);
      if (push && !pop)      count_d = CW'(count_q + 1'b1);
      else if (pop && !push) count_d = CW'(count_q - 1'b1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  queue_storage #(.DEPTH(DEPTH), .W(N)) u_instr (
    .clock   (clock),
    .reset   (reset),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (q.in_instr),
    .raddr_i (rd_ptr_q),
    .rdata_o (q.out_instr)
  );

`ifdef INSTRUCTION_QUEUE_PC_TAG_EN
  queue_storage #(.DEPTH(DEPTH), .W(AW)) u_pc (
    .clock   (clock),
    .reset   (reset),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (q.in_pc),
    .raddr_i (rd_ptr_q),
    .rdata_o (q.out_pc)
  );
`else
  logic unused_pc;
  assign unused_pc = ^q.in_pc;
  assign q.out_pc  = '0;
`endif
endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue with a queue-based reference model.
module tb_instruction_queue;
  import legv8_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    instr_t instr;
    pc_t    pc;
  } entry_t;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  entry_t mq[$];

  instruction_queue_if #(.N(32), .AW(64), .CW(CW)) bus ();

  instruction_queue #(.N(32), .DEPTH(DEPTH), .AW(64)) dut (
    .clock (clock),
    .reset (reset),
    .q     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic pc_t pc_exp(input pc_t p);
`ifdef INSTRUCTION_QUEUE_PC_TAG_EN
    return p;
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO semantics stated at transaction level.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      bit do_push, do_pop;
      entry_t e;
      do_push = bus.in_valid && (mq.size() < DEPTH);
      do_pop  = bus.out_ready && (mq.size() != 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.instr = bus.in_instr;
        e.pc    = bus.in_pc;
        mq.push_back(e);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
    if (mq.size() != 0) begin
      chk("out_instr", 64'(bus.out_instr), 64'(mq[0].instr));
      chk("out_pc", bus.out_pc, pc_exp(mq[0].pc));
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push1(input instr_t i, input pc_t p);
    bus.in_valid = 1'b1;
    bus.in_instr = i;
    bus.in_pc    = p;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_out_pc", bus.out_pc, 64'd0);

    // Single push into empty queue, one cycle latency
    push1(32'h8B020020, 64'h100);
    chk("p1_valid", 64'(bus.out_valid), 64'd1);
    chk("p1_instr", 64'(bus.out_instr), 64'h8B020020);
    chk("p1_pc", bus.out_pc, pc_exp(64'h100));
    chk("p1_count", 64'(bus.count), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("p1_drained", 64'(bus.out_valid), 64'd0);

    // Fill to full, fifth push dropped, drain in order
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = 32'hA0 + 32'(i);
      bus.in_pc    = 64'h1000 + 64'(4 * i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_instr", 64'(bus.out_instr), 64'hA0 + 64'(i));
      bus.out_ready = 1'b1;
      tick();
    end
    bus.out_ready = 1'b0;
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    // Streaming push+pop with two entries resident; pointers wrap
    push1(32'hB0, 64'h2000);
    push1(32'hB1, 64'h2004);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'hC0 + 32'(i);
      bus.in_pc     = 64'h3000 + 64'(4 * i);
      bus.out_ready = 1'b1;
      if (i == 0) chk("stream_head0", 64'(bus.out_instr), 64'hB0);
      if (i == 2) chk("stream_head2", 64'(bus.out_instr), 64'hC0);
      tick();
      chk("stream_count", 64'(bus.count), 64'd2);
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.out_ready = 1'b0;
    chk("stream_empty", 64'(bus.count), 64'd0);

    // Flush beats simultaneous push and pop
    push1(32'hD0, 64'h4000);
    push1(32'hD1, 64'h4004);
    push1(32'hD2, 64'h4008);
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'hD3;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_ready", 64'(bus.in_ready), 64'd1);
    push1(32'hE0, 64'h5000);
    chk("post_flush_head", 64'(bus.out_instr), 64'hE0);
    chk("post_flush_count", 64'(bus.count), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Asynchronous reset mid-cycle
    push1(32'hF0, 64'h6000);
    push1(32'hF1, 64'h6004);
    chk("pre_rst_count", 64'(bus.count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_count", 64'(bus.count), 64'd0);
    tick();
    reset = 1'b0;

    // PC tag path (zero when the tag array is not built)
    push1(32'h91000421, 64'h200);
    chk("tag_instr", 64'(bus.out_instr), 64'h91000421);
    chk("tag_pc", bus.out_pc, pc_exp(64'h200));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1);
  end
endmodule
